// File: rtl/mul_pkg.sv
// Shared types and helpers for the pipelined M-extension multiplier.
package mul_pkg;

  localparam int unsigned MUL_OP_W = 2;

  typedef enum logic [MUL_OP_W-1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } mul_op_e;

  function automatic logic op_a_signed(mul_op_e op);
    return (op == MULH) || (op == MULHSU);
  endfunction

  function automatic logic op_b_signed(mul_op_e op);
    return op == MULH;
  endfunction

endpackage

// File: rtl/mul_pipe_slot.sv
// One pipeline slot: reset/flushable valid bit plus an unreset payload register.
module mul_pipe_slot #(
  parameter int unsigned W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en_i,
  input  logic         flush_i,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_d, valid_q;
  logic [W-1:0] data_d, data_q;

  always_comb begin
    valid_d = valid_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (en_i) begin
      valid_d = valid_i;
    end
    data_d = en_i ? data_i : data_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clock) begin
    data_q <= data_d;
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/mul_pipe_unit.sv
// Pipelined RV32/RV64 M-extension multiplier with valid/ready handshakes, flush and tag.
module mul_pipe_unit
  import mul_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned STAGES = 3,
  parameter int unsigned TAG_W  = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [MUL_OP_W-1:0] in_op,
  input  logic [XLEN-1:0]     in_a,
  input  logic [XLEN-1:0]     in_b,
  input  logic [TAG_W-1:0]    in_tag,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_res,
  output logic [TAG_W-1:0]    out_tag,
  output logic                busy
);

  localparam int unsigned W = TAG_W + XLEN;

  mul_op_e           op;
  logic [XLEN:0]     a_ext, b_ext;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   res;
  logic              advance;

  logic [STAGES:0] valid_chain;
  logic [W-1:0]    data_chain [STAGES+1];

  // Only the low 2*XLEN product bits are ever selected, so operands are
  // extended to exactly that width.
  always_comb begin
    op    = mul_op_e'(in_op);
    a_ext = {op_a_signed(op) & in_a[XLEN-1], in_a};
    b_ext = {op_b_signed(op) & in_b[XLEN-1], in_b};
    prod  = {{(XLEN-1){a_ext[XLEN]}}, a_ext} * {{(XLEN-1){b_ext[XLEN]}}, b_ext};
    res   = (op == MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  assign advance        = !out_valid || out_ready;
  assign in_ready       = advance;
  assign valid_chain[0] = in_valid;
  assign data_chain[0]  = {in_tag, res};

  for (genvar s = 0; s < STAGES; s++) begin : g_slot
    mul_pipe_slot #(
      .W(W)
    ) u_slot (
      .clock   (clock),
      .reset   (reset),
      .en_i    (advance),
      .flush_i (flush),
      .valid_i (valid_chain[s]),
      .data_i  (data_chain[s]),
      .valid_o (valid_chain[s+1]),
      .data_o  (data_chain[s+1])
    );
  end

  // Payload is unreset; gating by valid keeps the outputs at zero after reset.
  always_comb begin
    out_valid = valid_chain[STAGES];
    out_res   = out_valid ? data_chain[STAGES][XLEN-1:0] : '0;
    out_tag   = out_valid ? data_chain[STAGES][W-1:XLEN] : '0;
    busy      = |valid_chain[STAGES:1];
  end

endmodule

// File: tb/tb_mul_pipe_unit.sv
// Directed self-checking bench: a 32-bit/3-stage unit and a 64-bit/1-stage unit.
module tb_mul_pipe_unit;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // 32-bit, 3-stage instance
  logic        in_valid, in_ready, flush, out_valid, out_ready, busy;
  logic [1:0]  in_op;
  logic [31:0] in_a, in_b, out_res;
  logic [3:0]  in_tag, out_tag;

  mul_pipe_unit #(.XLEN(32), .STAGES(3), .TAG_W(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_tag   (out_tag),
    .busy      (busy)
  );

  // 64-bit, 1-stage instance
  logic        w_in_valid, w_in_ready, w_out_valid, w_busy;
  logic [1:0]  w_in_op;
  logic [63:0] w_in_a, w_in_b, w_out_res;
  logic [3:0]  w_in_tag, w_out_tag;

  mul_pipe_unit #(.XLEN(64), .STAGES(1), .TAG_W(4)) dut64 (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (w_in_valid),
    .in_ready  (w_in_ready),
    .in_op     (w_in_op),
    .in_a      (w_in_a),
    .in_b      (w_in_b),
    .in_tag    (w_in_tag),
    .flush     (1'b0),
    .out_valid (w_out_valid),
    .out_ready (1'b1),
    .out_res   (w_out_res),
    .out_tag   (w_out_tag),
    .busy      (w_busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] t);
    in_valid = v;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = t;
  endtask

  logic [31:0] hi_a [4] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
  logic [1:0]  hi_op [4] = '{2'b01, 2'b01, 2'b11, 2'b10};
  logic [31:0] hi_exp [4] = '{32'h4000_0000, 32'h0000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};

  initial begin
    int next_in;
    int idx_out;
    drive(1'b0, 2'b00, 32'd0, 32'd0, 4'd0);
    flush      = 1'b0;
    out_ready  = 1'b1;
    w_in_valid = 1'b0;
    w_in_op    = 2'b00;
    w_in_a     = '0;
    w_in_b     = '0;
    w_in_tag   = '0;

    // Reset state
    tick();
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_out_res", {32'd0, out_res}, 64'd0);
    check("rst_out_tag", {60'd0, out_tag}, 64'd0);
    tick();
    reset = 1'b0;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);

    // Basic MUL latency
    drive(1'b1, 2'b00, 32'd7, 32'd6, 4'd5);
    tick();
    drive(1'b0, 2'b00, 32'd0, 32'd0, 4'd0);
    check("lat_c1", {63'd0, out_valid}, 64'd0);
    tick();
    check("lat_c2", {63'd0, out_valid}, 64'd0);
    tick();
    check("lat_c3_valid", {63'd0, out_valid}, 64'd1);
    check("lat_c3_res", {32'd0, out_res}, 64'h2A);
    check("lat_c3_tag", {60'd0, out_tag}, 64'd5);
    tick();
    check("lat_c4_valid", {63'd0, out_valid}, 64'd0);

    // High forms, one per cycle
    for (int k = 0; k < 7; k++) begin
      if (k < 4) drive(1'b1, hi_op[k], hi_a[k], hi_a[k], 4'(k));
      else drive(1'b0, 2'b00, 32'd0, 32'd0, 4'd0);
      tick();
      if (k >= 2 && k < 6) begin
        check("hi_valid", {63'd0, out_valid}, 64'd1);
        check("hi_res", {32'd0, out_res}, {32'd0, hi_exp[k-2]});
        check("hi_tag", {60'd0, out_tag}, 64'(k - 2));
      end else if (k == 6) begin
        check("hi_drained", {63'd0, out_valid}, 64'd0);
      end
    end

    // Backpressure: fill with out_ready low
    out_ready = 1'b0;
    for (int t = 1; t <= 3; t++) begin
      drive(1'b1, 2'b00, 32'(t), 32'd10, 4'(t));
      check("bp_fill_ready", {63'd0, in_ready}, 64'd1);
      tick();
    end
    drive(1'b1, 2'b00, 32'd4, 32'd10, 4'd4);
    for (int s = 0; s < 3; s++) begin
      check("bp_stall_ready", {63'd0, in_ready}, 64'd0);
      check("bp_stall_valid", {63'd0, out_valid}, 64'd1);
      check("bp_stall_tag", {60'd0, out_tag}, 64'd1);
      check("bp_stall_res", {32'd0, out_res}, 64'd10);
      check("bp_stall_busy", {63'd0, busy}, 64'd1);
      tick();
    end
    out_ready = 1'b1;
    next_in = 4;
    idx_out = 1;
    for (int c = 0; c < 20; c++) begin
      if (out_valid) begin
        if (idx_out > 5) check("bp_extra_result", 64'd1, 64'd0);
        else begin
          check("bp_drain_tag", {60'd0, out_tag}, 64'(idx_out));
          check("bp_drain_res", {32'd0, out_res}, 64'(idx_out * 10));
        end
        idx_out++;
      end
      if (in_valid && in_ready) begin
        next_in++;
        if (next_in <= 5) drive(1'b1, 2'b00, 32'(next_in), 32'd10, 4'(next_in));
        else drive(1'b0, 2'b00, 32'd0, 32'd0, 4'd0);
      end
      tick();
    end
    check("bp_drain_count", 64'(idx_out - 1), 64'd5);

    // Flush with a concurrent input
    for (int t = 1; t <= 3; t++) begin
      drive(1'b1, 2'b00, 32'(t), 32'd3, 4'(t));
      tick();
    end
    drive(1'b1, 2'b00, 32'd9, 32'd9, 4'd9);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 2'b00, 32'd0, 32'd0, 4'd0);
    check("fl_out_valid", {63'd0, out_valid}, 64'd0);
    check("fl_busy", {63'd0, busy}, 64'd0);
    for (int c = 0; c < 4; c++) begin
      tick();
      check("fl_no_ghost", {63'd0, out_valid}, 64'd0);
    end
    drive(1'b1, 2'b00, 32'd5, 32'd5, 4'd7);
    tick();
    drive(1'b0, 2'b00, 32'd0, 32'd0, 4'd0);
    tick();
    check("fl_post_c2", {63'd0, out_valid}, 64'd0);
    tick();
    check("fl_post_valid", {63'd0, out_valid}, 64'd1);
    check("fl_post_res", {32'd0, out_res}, 64'd25);
    check("fl_post_tag", {60'd0, out_tag}, 64'd7);
    tick();

    // Asynchronous reset while ops are in flight
    drive(1'b1, 2'b00, 32'd2, 32'd2, 4'd1);
    tick();
    drive(1'b1, 2'b00, 32'd3, 32'd3, 4'd2);
    tick();
    drive(1'b0, 2'b00, 32'd0, 32'd0, 4'd0);
    tick();
    check("ar_pre_valid", {63'd0, out_valid}, 64'd1);
    #2 reset = 1'b1;
    #1;
    check("ar_out_valid", {63'd0, out_valid}, 64'd0);
    check("ar_busy", {63'd0, busy}, 64'd0);
    check("ar_out_res", {32'd0, out_res}, 64'd0);
    tick();
    reset = 1'b0;
    check("ar_in_ready", {63'd0, in_ready}, 64'd1);
    for (int c = 0; c < 4; c++) begin
      tick();
      check("ar_no_stale", {63'd0, out_valid | busy}, 64'd0);
    end

    // 64-bit, single stage
    w_in_valid = 1'b1;
    w_in_op    = 2'b11;
    w_in_a     = 64'hFFFF_FFFF_FFFF_FFFF;
    w_in_b     = 64'd2;
    w_in_tag   = 4'd3;
    tick();
    w_in_op  = 2'b00;
    w_in_a   = 64'h1_0000_0000;
    w_in_b   = 64'h1_0000_0000;
    w_in_tag = 4'd4;
    check("w_mulhu_valid", {63'd0, w_out_valid}, 64'd1);
    check("w_mulhu_res", w_out_res, 64'd1);
    check("w_mulhu_tag", {60'd0, w_out_tag}, 64'd3);
    tick();
    w_in_valid = 1'b0;
    check("w_mul_valid", {63'd0, w_out_valid}, 64'd1);
    check("w_mul_res", w_out_res, 64'd0);
    check("w_mul_tag", {60'd0, w_out_tag}, 64'd4);
    tick();
    check("w_idle", {63'd0, w_out_valid}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/mul_pipe_unit.md
Name: mul_pipe_unit

Overview:
- Parametrised, pipelined RV32/RV64 M-extension multiplier; successor to the single-cycle multiply debug block.
- Adds configurable XLEN and latency, valid/ready handshakes on input and output, backpressure, flush, and a tag that travels with each operation.
- Sits in the EXU beside the ALU; issue drives the input side, writeback/commit drains the output side.

Parameters:
- XLEN, 32, operand/result width (32 or 64).
- STAGES, 3, register stages from acceptance to result presentation; must be ≥1.
- TAG_W, 4, width of the opaque tag carried with each op (ROB/tracking id).

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept this cycle.
- in_op  in  2  operation: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- in_a  in  XLEN  rs1 operand.
- in_b  in  XLEN  rs2 operand.
- in_tag  in  TAG_W  opaque tag.
- flush  in  1  kill all in-flight ops.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_res  out  XLEN  result.
- out_tag  out  TAG_W  tag of the result.
- busy  out  1  any stage holds a valid op.

Behaviour:
- Reset (async, any time, including mid-operation): all stage valid bits cleared; out_valid=0, busy=0, out_res=0, out_tag=0; in_ready=1 from the first cycle after reset deasserts.
- Arithmetic:
  - a is sign-extended to XLEN+1 bits for MULH/MULHSU and zero-extended otherwise.
  - b is sign-extended for MULH and zero-extended otherwise.
  - Full product is 2*XLEN+2 bits, signed.
  - MUL returns product[XLEN-1:0]; the three high forms return product[2XLEN-1:XLEN].
- Pipeline: a chain of STAGES slots, each holding valid, op, tag, and partial/full product state. Retiming of the multiply across slots is allowed; only the interface timing is fixed.
- Advance rule: advance = !out_valid || out_ready. The whole pipe shifts when advance=1 and freezes otherwise. Bubbles are not collapsed.
- in_ready = advance. A transfer occurs when in_valid && in_ready.
- out_valid = valid bit of the last slot; out_res and out_tag come from that slot and are held stable while out_valid && !out_ready.
- Latency: an op accepted in cycle t presents out_valid in cycle t+STAGES when there is no stall. Each stall cycle adds 1.
- Throughput: 1 op/cycle when out_ready is held high.
- Ordering: results leave in acceptance order. No loss, no duplication.
- Output handshake: a result is consumed only in a cycle with out_valid && out_ready. The same cycle's advance moves the next slot into the output.
- Flush:
  - Synchronous; on the next edge all valid bits are cleared.
  - An input presented in the flush cycle is dropped, even if in_ready=1.
  - out_valid must be ignored by the consumer in the flush cycle; it is 0 from the next cycle.
  - flush takes priority over advance and acceptance.
- busy = OR of all slot valid bits.
- Payload registers (op, a, b, partial products, tag) need no reset; only valid bits and the output registers are reset.

Decomposition:
- Package mul_pkg:
  - mul_op_e enum (MUL=2'b00, MULH=2'b01, MULHSU=2'b10, MULHU=2'b11).
  - Helper functions op_a_signed(op) and op_b_signed(op).
  - Constant MUL_OP_W=2.
- One sub-module, mul_pipe_slot: a single stage register with valid, payload, enable (advance) and flush, instantiated STAGES times by a generate loop. The multiply datapath stays in the top module.

Test Plan:
- XLEN=32, STAGES=3, out_ready=1. Issue MUL 7*6 with tag 5 at cycle 0 → out_valid at cycle 3, out_res=0x0000002A, out_tag=5.
- High forms, one op per cycle, out_ready=1:
  - MULH 0x80000000*0x80000000 → 0x40000000.
  - MULH 0xFFFFFFFF*0xFFFFFFFF → 0x00000000.
  - MULHU 0xFFFFFFFF*0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF*0xFFFFFFFF → 0xFFFFFFFF.
  - Results appear on consecutive cycles 3..6.
- Backpressure:
  - Hold out_ready=0 and offer 5 back-to-back ops with tags 1..5.
  - Tag 1 stalls at the output (out_valid=1) while tags 2 and 3 are accepted behind it.
  - in_ready drops once the pipe is full; tag 4 is held at the input with in_valid=1, and tag 5 is not yet presented.
  - out_res stays stable during the stall.
  - Release out_ready → tags 1..5 emerge in order, each exactly once.
- Flush:
  - Accept 3 ops, then assert flush together with a 4th in_valid.
  - Next cycle: out_valid=0 and busy=0.
  - The 4th op never appears, and ops issued afterwards return with normal latency.
- Async reset mid-stream: assert reset between clock edges while 2 ops are in flight → out_valid and busy drop immediately with no clock edge; no stale result appears after reset is released.
- XLEN=64, STAGES=1:
  - MULHU 0xFFFFFFFFFFFFFFFF*2 → 0x0000000000000001, latency 1.
  - MUL 0x100000000*0x100000000 → 0.
